mult_pipe: RTL and testbench
============================

MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 4..16.
REQ-002 Parameter STAGES, default 3: pipeline latency in cycles, legal range 2..4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair on a/b/sgn is valid.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 sgn  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-010 out_valid  output  1  p holds a valid product.
REQ-011 out_ready  input  1  consumer takes p this cycle.
REQ-012 p  output  2*WIDTH  registered product.

Function
REQ-013 An input is accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-014 A product is delivered on a rising clk edge where out_valid and out_ready are both 1.
REQ-015 Global advance enable en = !out_valid | out_ready; in_ready SHALL equal en combinationally.
REQ-016 When en=1, every stage register and its valid bit SHALL load from the preceding stage; when en=0, all stages SHALL hold.
REQ-017 When en=1 and in_valid=0, a bubble SHALL be inserted: stage-0 valid = 0 and its data is don't-care.
REQ-018 With out_ready held at 1, an input accepted at edge n SHALL produce out_valid=1 with its product after edge n+STAGES.
REQ-019 Sustained throughput SHALL be one product per cycle while in_valid and out_ready are both 1.
REQ-020 Stage 0 SHALL register a, b and sgn; later stages SHALL sum partial products as an adder tree, with the tree levels split evenly across stages 1..STAGES-1.
REQ-021 For unsigned operands, p SHALL equal a*b zero-extended to 2*WIDTH bits.
REQ-022 For signed operands, p SHALL equal the exact two's-complement product in 2*WIDTH bits; (-2^(WIDTH-1))*(-2^(WIDTH-1)) SHALL yield +2^(2*WIDTH-2) with no overflow.
REQ-023 sgn SHALL travel with its operands; mixed signed and unsigned inputs in consecutive cycles SHALL each be computed correctly.
REQ-024 While out_valid=1 and out_ready=0, p and out_valid SHALL stay stable, and no accepted input SHALL be lost or duplicated.
REQ-025 p SHALL hold its last value when out_valid=0; consumers treat it as don't-care.

Reset
REQ-026 While rst=1, all stage valid bits and out_valid SHALL be 0, p SHALL be 0, and all data registers SHALL be 0.
REQ-027 in_ready SHALL be 1 during reset and on the first cycle after reset.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operands; after rst deasserts, no product from before reset SHALL appear.

Configuration
REQ-029 Macro MULT_PIPE_SIGNED_EN defined: sgn is honoured per REQ-009/REQ-022.
REQ-030 Macro MULT_PIPE_SIGNED_EN undefined: the sgn port remains present but is ignored; all operands are unsigned and no sign-handling logic is synthesised.

Verification
REQ-031 WIDTH=4, STAGES=2, unsigned, all 256 (a,b) pairs back-to-back, out_ready=1 -> each p = a*b exactly 2 cycles after acceptance; 256 outputs in order.
REQ-032 WIDTH=8, signed (macro on): a=8'h80, b=8'h80 -> p=16'h4000; a=8'hFF, b=8'h02 -> p=16'hFFFE; a=8'hFF, b=8'h02 with sgn=0 -> p=16'h01FE.
REQ-033 WIDTH=8, STAGES=3: stream 10 inputs while out_ready toggles 1,0,0,1 repeatedly -> all 10 products appear in order, none dropped or duplicated, p stable while stalled.
REQ-034 in_valid pattern 1,0,1,0,1 -> out_valid pattern is the same sequence delayed by STAGES cycles.
REQ-035 Assert rst for 1 cycle while 3 products are in flight -> out_valid=0 and p=0 immediately; no stale product after release; the next input yields the correct result after STAGES cycles.
REQ-036 Macro off, a=8'hFF, b=8'hFF, sgn=1 -> p=16'hFE01.

Source files
------------

// File: rtl/mult_pipe.sv
// mult_pipe -- pipelined WIDTH x WIDTH multiplier with valid/ready flow control.
//
// Pipeline layout (latency STAGES cycles, one product per cycle sustained):
//   stage 0          : registers a, b (and sgn when signed support is built)
//   stages 1..S-1    : stage 1 holds the partial products; the adder-tree
//                      levels are split evenly over the STAGES-1 register
//                      boundaries that follow it
//   stage S (p)      : the finished product
// A single global enable (en = !out_valid | out_ready) advances every stage at
// once, so a stall at the output freezes the whole pipe without losing data.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears valids and all data)
//   in_valid   operand pair on a/b/sgn is valid
//   in_ready   pipe accepts the pair this cycle (equals en)
//   a, b       WIDTH-bit multiplicand / multiplier
//   sgn        1 = two's-complement operands, 0 = unsigned
//   out_valid  p holds a valid product
//   out_ready  consumer takes p this cycle
//   p          2*WIDTH-bit registered product (holds when no new product)
//
// Configuration macro: MULT_PIPE_SIGNED_EN
//   defined   : sgn selects signed or unsigned multiplication per operand pair
//   undefined : sgn is ignored, all operands are unsigned, no sign logic built

module mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW      = 2 * WIDTH;
    localparam int LVLS    = $clog2(WIDTH);
    localparam int NPOW    = 1 << LVLS;
    localparam int TREE_ST = STAGES - 1;

    typedef logic [PW-1:0]    word_t;
    typedef word_t [NPOW-1:0] vec_t;

    // Last tree level finished by the boundary after tree stage c.
    function automatic int level_end(input int c);
        return (c * LVLS) / TREE_ST;
    endfunction

    // Apply nlev pairwise-addition levels; results are compacted toward index 0.
    function automatic vec_t reduce_levels(input vec_t v, input int nlev);
        vec_t acc;
        vec_t nxt;
        acc = v;
        for (int l = 0; l < LVLS; l++) begin
            if (l < nlev) begin
                nxt = '0;
                for (int i = 0; i < NPOW / 2; i++) begin
                    nxt[i] = acc[2*i] + acc[2*i+1];
                end
                acc = nxt;
            end
        end
        return acc;
    endfunction

    function automatic word_t reduce_final(input vec_t v, input int nlev);
        vec_t r;
        r = reduce_levels(v, nlev);
        return r[0];
    endfunction

`ifdef MULT_PIPE_SIGNED_EN
    function automatic vec_t gen_pp(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y,
                                    input logic             s);
        vec_t                 pp;
        logic signed [PW-1:0] x_ext;
        pp    = '0;
        x_ext = {{WIDTH{s & x[WIDTH-1]}}, x};
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (y[i]) pp[i] = x_ext << i;
        end
        // The multiplier MSB weighs -2^(WIDTH-1) in two's complement, so its
        // partial product is negated; everything is summed modulo 2^PW.
        if (y[WIDTH-1]) pp[WIDTH-1] = (s ? -x_ext : x_ext) << (WIDTH - 1);
        return pp;
    endfunction
`else
    function automatic vec_t gen_pp(input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y);
        vec_t  pp;
        word_t x_ext;
        pp    = '0;
        x_ext = {{WIDTH{1'b0}}, x};
        for (int i = 0; i < WIDTH; i++) begin
            if (y[i]) pp[i] = x_ext << i;
        end
        return pp;
    endfunction

    logic unused_sgn;
    assign unused_sgn = sgn;
`endif

    logic             en;
    logic [STAGES:0]  vld_q, vld_d;
    logic [WIDTH-1:0] a_p0_q, a_p0_d;
    logic [WIDTH-1:0] b_p0_q, b_p0_d;
`ifdef MULT_PIPE_SIGNED_EN
    logic             sgn_p0_q, sgn_p0_d;
`endif
    vec_t             tree_q [1:TREE_ST];
    vec_t             tree_d [1:TREE_ST];
    word_t            p_q, p_d;

    always_comb begin
        en     = !vld_q[STAGES] || out_ready;
        vld_d  = vld_q;
        a_p0_d = a_p0_q;
        b_p0_d = b_p0_q;
`ifdef MULT_PIPE_SIGNED_EN
        sgn_p0_d = sgn_p0_q;
`endif
        tree_d = tree_q;
        p_d    = p_q;
        if (en) begin
            // A bubble simply shifts a 0 into the valid chain.
            vld_d = {vld_q[STAGES-1:0], in_valid};

            // ---- stage 0: operand capture ----
            a_p0_d = a;
            b_p0_d = b;
`ifdef MULT_PIPE_SIGNED_EN
            sgn_p0_d = sgn;

            // ---- stage 1: partial products ----
            tree_d[1] = gen_pp(a_p0_q, b_p0_q, sgn_p0_q);
`else
            // ---- stage 1: partial products ----
            tree_d[1] = gen_pp(a_p0_q, b_p0_q);
`endif

            // ---- stages 2..STAGES-1: adder-tree slices ----
            for (int c = 2; c <= TREE_ST; c++) begin
                tree_d[c] = reduce_levels(tree_q[c-1],
                                          level_end(c-1) - level_end(c-2));
            end

            // ---- stage STAGES: final tree slice into p ----
            // p only updates with a real product so it holds across bubbles.
            if (vld_q[STAGES-1]) begin
                p_d = reduce_final(tree_q[TREE_ST],
                                   level_end(TREE_ST) - level_end(TREE_ST-1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            a_p0_q <= '0;
            b_p0_q <= '0;
`ifdef MULT_PIPE_SIGNED_EN
            sgn_p0_q <= 1'b0;
`endif
            for (int c = 1; c <= TREE_ST; c++) begin
                tree_q[c] <= '0;
            end
            p_q <= '0;
        end else begin
            vld_q  <= vld_d;
            a_p0_q <= a_p0_d;
            b_p0_q <= b_p0_d;
`ifdef MULT_PIPE_SIGNED_EN
            sgn_p0_q <= sgn_p0_d;
`endif
            tree_q <= tree_d;
            p_q    <= p_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[STAGES];
    assign p         = p_q;

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe -- self-checking bench for mult_pipe.
// Two instances: WIDTH=8/STAGES=3 (random, stall, pattern and reset tests) and
// WIDTH=4/STAGES=2 (exhaustive unsigned sweep with exact-latency check).
// Expected products come from plain integer multiplication kept in queues.
`timescale 1ns/1ps
module tb_mult_pipe;

    localparam int W8 = 8;
    localparam int S8 = 3;
    localparam int W4 = 4;
    localparam int S4 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid8, in_ready8, out_valid8, out_ready8, sgn8;
    logic [W8-1:0] a8, b8;
    logic [15:0]   p8;

    logic          in_valid4, in_ready4, out_valid4, out_ready4, sgn4;
    logic [W4-1:0] a4, b4;
    logic [7:0]    p4;

    mult_pipe #(.WIDTH(W8), .STAGES(S8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sgn(sgn8),
        .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
    );

    mult_pipe #(.WIDTH(W4), .STAGES(S4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sgn(sgn4),
        .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int prod;
        bit use_sgn;
`ifdef MULT_PIPE_SIGNED_EN
        use_sgn = 1'b1;
`else
        use_sgn = 1'b0;
`endif
        if (use_sgn && s) prod = int'($signed(x)) * int'($signed(y));
        else              prod = int'(x) * int'(y);
        return prod[15:0];
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y);
        int prod;
        prod = int'(x) * int'(y);
        return prod[7:0];
    endfunction

    typedef struct { logic [15:0] p; int c; } exp8_t;
    typedef struct { logic [7:0]  p; int c; } exp4_t;
    exp8_t q8[$];
    exp4_t q4[$];
    int delivered8 = 0;
    int delivered4 = 0;
    bit          hold8_pend = 1'b0;
    logic [15:0] hold8_p = '0;

    // Scoreboard: observe handshakes at the falling edge, before the rising
    // edge that completes them.
    always @(negedge clk) begin
        exp8_t e8;
        exp4_t e4;
        if (rst) begin
            q8.delete();
            q4.delete();
            hold8_pend = 1'b0;
        end else begin
            if (hold8_pend) begin
                chk("stall_hold_valid", 32'(out_valid8), 32'd1);
                chk("stall_hold_p", 32'(p8), 32'(hold8_p));
            end
            hold8_pend = out_valid8 && !out_ready8;
            hold8_p    = p8;
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_out8", 32'(out_valid8), 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    chk("product8", 32'(p8), 32'(e8.p));
                end
                delivered8++;
            end
            if (in_valid8 && in_ready8) q8.push_back('{model8(a8, b8, sgn8), cyc});

            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_out4", 32'(out_valid4), 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    chk("product4", 32'(p4), 32'(e4.p));
                    chk("latency4", 32'(cyc - e4.c), 32'(S4 + 1));
                end
                delivered4++;
            end
            if (in_valid4 && in_ready4) q4.push_back('{model4(a4, b4), cyc});
        end
    end

    // One accepted pair, then check out_valid is low one cycle early and the
    // product is present exactly STAGES edges after acceptance.
    task automatic directed8(input string name, input logic [7:0] x, input logic [7:0] y,
                             input logic s, input logic [15:0] exp);
        @(posedge clk); #1;
        out_ready8 = 1'b1; in_valid8 = 1'b1; a8 = x; b8 = y; sgn8 = s;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (S8 - 1) @(posedge clk);
        #1;
        chk({name, "_early"}, 32'(out_valid8), 32'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 32'(out_valid8), 32'd1);
        chk(name, 32'(p8), 32'(exp));
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [7:0] pick8();
        logic [7:0] corners [4];
        corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         sent, d0, k, idx, n;
        logic [4:0] pat;
        logic [7:0] iv, ra, rb;
        logic       rs;
        logic [15:0] e_80_80, e_ff_02_s, e_ff_02_u, e_ff_ff_s;

`ifdef MULT_PIPE_SIGNED_EN
        e_80_80 = 16'h4000; e_ff_02_s = 16'hFFFE; e_ff_02_u = 16'h01FE; e_ff_ff_s = 16'h0001;
`else
        e_80_80 = 16'h4000; e_ff_02_s = 16'h01FE; e_ff_02_u = 16'h01FE; e_ff_ff_s = 16'hFE01;
`endif

        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sgn8 = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; sgn4 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid8", 32'(out_valid8), 32'd0);
        chk("rst_p8", 32'(p8), 32'd0);
        chk("rst_in_ready8", 32'(in_ready8), 32'd1);
        chk("rst_out_valid4", 32'(out_valid4), 32'd0);
        chk("rst_p4", 32'(p4), 32'd0);
        chk("rst_in_ready4", 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready8", 32'(in_ready8), 32'd1);

        // Hand-computed products, including the most-negative square
        directed8("p_80x80_s", 8'h80, 8'h80, 1'b1, e_80_80);
        directed8("p_ffx02_s", 8'hFF, 8'h02, 1'b1, e_ff_02_s);
        directed8("p_ffx02_u", 8'hFF, 8'h02, 1'b0, e_ff_02_u);
        directed8("p_ffxff_s", 8'hFF, 8'hFF, 1'b1, e_ff_ff_s);

        // in_valid 1,0,1,0,1 -> same out_valid sequence STAGES cycles later
        pat = 5'b10101;
        for (int j = 0; j <= 5 + S8; j++) begin
            @(posedge clk); #1;
            in_valid8 = (j < 5) ? pat[j] : 1'b0;
            a8 = pick8(); b8 = pick8(); sgn8 = 1'($urandom);
            @(negedge clk);
            idx = j - S8 - 1;
            chk("vld_pattern", 32'(out_valid8),
                32'((idx >= 0 && idx < 5) ? pat[idx] : 1'b0));
        end

        // 10 inputs with out_ready toggling 1,0,0,1
        sent = 0; k = 0; d0 = delivered8;
        while ((sent < 10 || delivered8 - d0 < 10) && k < 200) begin
            @(posedge clk); #1;
            out_ready8 = (k % 4 == 0) || (k % 4 == 3);
            in_valid8  = (sent < 10);
            a8 = pick8(); b8 = pick8(); sgn8 = 1'($urandom);
            @(negedge clk);
            if (in_valid8 && in_ready8) sent++;
            k++;
        end
        chk("stall_stream_count", 32'(delivered8 - d0), 32'd10);

        // Random traffic with random back-pressure and mixed sgn
        for (int j = 0; j < 400; j++) begin
            @(posedge clk); #1;
            in_valid8  = ($urandom_range(0, 9) < 7);
            out_ready8 = ($urandom_range(0, 9) < 6);
            a8 = pick8(); b8 = pick8(); sgn8 = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        n = 0;
        while (q8.size() != 0 && n < 50) begin
            @(posedge clk); n++;
        end
        #1;
        chk("drain8", 32'(q8.size()), 32'd0);

        // Exhaustive WIDTH=4 unsigned sweep, back-to-back
        d0 = delivered4;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            iv = 8'(i);
            in_valid4 = 1'b1; a4 = iv[7:4]; b4 = iv[3:0];
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (S4 + 3) @(posedge clk);
        #1;
        chk("w4_count", 32'(delivered4 - d0), 32'd256);

        // Reset while three products are in flight
        out_ready8 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            in_valid8 = 1'b1; a8 = pick8(); b8 = pick8(); sgn8 = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid8", 32'(out_valid8), 32'd0);
        chk("midrst_p8", 32'(p8), 32'd0);
        chk("midrst_in_ready8", 32'(in_ready8), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("no_stale_out8", 32'(out_valid8), 32'd0);
        end
        ra = pick8(); rb = pick8(); rs = 1'($urandom);
        directed8("post_rst_product", ra, rb, rs, model8(ra, rb, rs));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
